// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single tiny5 memory port between the
// instruction-fetch requester and the data requester. Only one transaction
// is outstanding at a time. Data wins ties, but fetch is forced through
// after DMEM_MAX_CONSEC consecutive contended data grants. Fetch responses
// invalidated by a pipeline redirect are consumed silently.
module mem_port_arbiter #(
    parameter int DMEM_MAX_CONSEC = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        imem_req_valid_i,
    input  logic [31:0] imem_req_addr_i,
    output logic        imem_req_ready_o,
    output logic        imem_resp_valid_o,
    output logic [31:0] imem_resp_data_o,
    input  logic        dmem_req_valid_i,
    input  logic [31:0] dmem_req_addr_i,
    input  logic        dmem_req_we_i,
    input  logic [1:0]  dmem_req_size_i,
    input  logic [31:0] dmem_req_wdata_i,
    output logic        dmem_req_ready_o,
    output logic        dmem_resp_valid_o,
    output logic [31:0] dmem_resp_data_o,
    output logic        mem_req_valid_o,
    output logic [31:0] mem_req_addr_o,
    output logic        mem_req_we_o,
    output logic [1:0]  mem_req_size_o,
    output logic [31:0] mem_req_wdata_o,
    input  logic        mem_req_ready_i,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_resp_data_i,
    input  logic        flush_i
);

    localparam int CW = $clog2(DMEM_MAX_CONSEC + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT_I = 2'd1;
    localparam logic [1:0] S_WAIT_D = 2'd2;

    // mem_access_size_t encoding: BYTE = 0, HALF = 1, WORD = 2
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [CW-1:0] DCNT_MAX = CW'(DMEM_MAX_CONSEC);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] dcnt;
    logic          stale;

    logic          in_idle;
    logic          sel_d;
    logic          sel_i;
    logic          accept;
    logic          resp_in_wait_i;

    // Arbitration, request drive and response routing are all combinational
    // so that neither path adds latency.
    always_comb begin
        in_idle = (state == S_IDLE) && !reset_i;

        // Data wins ties unless fetch has been passed over too many times.
        sel_d = dmem_req_valid_i && (!imem_req_valid_i || (dcnt != DCNT_MAX));
        sel_i = imem_req_valid_i && !sel_d;

        mem_req_valid_o = in_idle && (imem_req_valid_i || dmem_req_valid_i);
        if (sel_d) begin
            mem_req_addr_o  = dmem_req_addr_i;
            mem_req_we_o    = dmem_req_we_i;
            mem_req_size_o  = dmem_req_size_i;
            mem_req_wdata_o = dmem_req_wdata_i;
        end else begin
            mem_req_addr_o  = imem_req_addr_i;
            mem_req_we_o    = 1'b0;
            mem_req_size_o  = SIZE_WORD;
            mem_req_wdata_o = 32'h0;
        end

        accept           = mem_req_valid_o && mem_req_ready_i;
        imem_req_ready_o = accept && sel_i;
        dmem_req_ready_o = accept && sel_d;

        // A fetch response is dropped if it was invalidated earlier (stale)
        // or by a redirect arriving in the very same cycle.
        resp_in_wait_i    = !reset_i && (state == S_WAIT_I) && mem_resp_valid_i;
        imem_resp_valid_o = resp_in_wait_i && !stale && !flush_i;
        dmem_resp_valid_o = !reset_i && (state == S_WAIT_D) && mem_resp_valid_i;

        imem_resp_data_o = mem_resp_data_i;
        dmem_resp_data_o = mem_resp_data_i;
    end

    // Next-state selection: IDLE -> WAIT_x on accept, WAIT_x -> IDLE on response.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (imem_req_ready_o) begin
                    state_nxt = S_WAIT_I;
                end else if (dmem_req_ready_o) begin
                    state_nxt = S_WAIT_D;
                end
            end
            S_WAIT_I, S_WAIT_D: begin
                if (mem_resp_valid_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register; reset abandons any outstanding transaction.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Count consecutive data grants taken while fetch was waiting.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dcnt <= '0;
        end else if (imem_req_ready_o) begin
            dcnt <= '0;
        end else if (dmem_req_ready_o) begin
            if (!imem_req_valid_i) begin
                dcnt <= '0;
            end else if (dcnt != DCNT_MAX) begin
                dcnt <= dcnt + CW'(1);
            end
        end
    end

    // Remember that the outstanding fetch was invalidated by a redirect.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stale <= 1'b0;
        end else if (state == S_WAIT_I) begin
            if (mem_resp_valid_i) begin
                stale <= 1'b0;
            end else if (flush_i) begin
                stale <= 1'b1;
            end
        end else if (imem_req_ready_o && flush_i) begin
            stale <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int MAXC = 4;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        imem_req_valid_i = 1'b0;
    logic [31:0] imem_req_addr_i = '0;
    logic        imem_req_ready_o;
    logic        imem_resp_valid_o;
    logic [31:0] imem_resp_data_o;
    logic        dmem_req_valid_i = 1'b0;
    logic [31:0] dmem_req_addr_i = '0;
    logic        dmem_req_we_i = 1'b0;
    logic [1:0]  dmem_req_size_i = 2'd2;
    logic [31:0] dmem_req_wdata_i = '0;
    logic        dmem_req_ready_o;
    logic        dmem_resp_valid_o;
    logic [31:0] dmem_resp_data_o;
    logic        mem_req_valid_o;
    logic [31:0] mem_req_addr_o;
    logic        mem_req_we_o;
    logic [1:0]  mem_req_size_o;
    logic [31:0] mem_req_wdata_o;
    logic        mem_req_ready_i = 1'b0;
    logic        mem_resp_valid_i = 1'b0;
    logic [31:0] mem_resp_data_i = '0;
    logic        flush_i = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model state: one outstanding transaction, its owner,
    // whether a fetch result must be thrown away, consecutive data wins.
    bit m_busy = 0;
    bit m_fetch = 0;
    bit m_drop = 0;
    int m_consec = 0;

    // Per-cycle expectations, produced in settle() and consumed in advance().
    bit e_acc, e_fetch, e_resp;
    bit last_iacc, last_dacc;
    bit grants[$];

    mem_port_arbiter #(.DMEM_MAX_CONSEC(MAXC)) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .imem_req_valid_i(imem_req_valid_i),
        .imem_req_addr_i(imem_req_addr_i),
        .imem_req_ready_o(imem_req_ready_o),
        .imem_resp_valid_o(imem_resp_valid_o),
        .imem_resp_data_o(imem_resp_data_o),
        .dmem_req_valid_i(dmem_req_valid_i),
        .dmem_req_addr_i(dmem_req_addr_i),
        .dmem_req_we_i(dmem_req_we_i),
        .dmem_req_size_i(dmem_req_size_i),
        .dmem_req_wdata_i(dmem_req_wdata_i),
        .dmem_req_ready_o(dmem_req_ready_o),
        .dmem_resp_valid_o(dmem_resp_valid_o),
        .dmem_resp_data_o(dmem_resp_data_o),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_req_we_o(mem_req_we_o),
        .mem_req_size_o(mem_req_size_o),
        .mem_req_wdata_o(mem_req_wdata_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_data_i(mem_resp_data_i),
        .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample mid-cycle and compare every output against the model.
    task automatic settle();
        bit want_d, e_mv, e_ir, e_dr, e_irv, e_drv;
        #3;
        e_mv = 0; e_ir = 0; e_dr = 0; e_irv = 0; e_drv = 0;
        e_acc = 0; e_resp = 0; e_fetch = 0;
        if (!reset_i) begin
            if (!m_busy) begin
                want_d  = dmem_req_valid_i && (!imem_req_valid_i || m_consec < MAXC);
                e_fetch = !want_d;
                e_mv    = imem_req_valid_i || dmem_req_valid_i;
                e_acc   = e_mv && mem_req_ready_i;
                e_ir    = e_acc && e_fetch;
                e_dr    = e_acc && !e_fetch;
            end else if (mem_resp_valid_i) begin
                e_resp = 1;
                e_irv  = m_fetch && !(m_drop || flush_i);
                e_drv  = !m_fetch;
            end
        end
        chk("mem_req_valid", mem_req_valid_o, e_mv);
        chk("imem_req_ready", imem_req_ready_o, e_ir);
        chk("dmem_req_ready", dmem_req_ready_o, e_dr);
        chk("imem_resp_valid", imem_resp_valid_o, e_irv);
        chk("dmem_resp_valid", dmem_resp_valid_o, e_drv);
        chk("imem_resp_data", imem_resp_data_o, mem_resp_data_i);
        chk("dmem_resp_data", dmem_resp_data_o, mem_resp_data_i);
        if (e_mv) begin
            chk("mem_req_addr", mem_req_addr_o, e_fetch ? imem_req_addr_i : dmem_req_addr_i);
            chk("mem_req_we", 32'(mem_req_we_o), e_fetch ? 32'd0 : 32'(dmem_req_we_i));
            chk("mem_req_size", 32'(mem_req_size_o), e_fetch ? 32'd2 : 32'(dmem_req_size_i));
            chk("mem_req_wdata", mem_req_wdata_o, e_fetch ? 32'd0 : dmem_req_wdata_i);
        end
        if (imem_req_ready_o) grants.push_back(1'b1);
        if (dmem_req_ready_o) grants.push_back(1'b0);
    endtask

    // Commit the model's view of this cycle, then move to just after the edge.
    task automatic advance();
        last_iacc = e_acc && e_fetch;
        last_dacc = e_acc && !e_fetch;
        if (reset_i) begin
            m_busy = 0; m_drop = 0; m_consec = 0;
        end else if (e_acc) begin
            m_busy  = 1;
            m_fetch = e_fetch;
            if (e_fetch) begin
                m_consec = 0;
                m_drop   = flush_i;
            end else begin
                m_consec = imem_req_valid_i ? ((m_consec < MAXC) ? m_consec + 1 : MAXC) : 0;
            end
        end else if (e_resp) begin
            m_busy = 0;
            m_drop = 0;
        end else if (m_busy && m_fetch && flush_i) begin
            m_drop = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    initial begin
        int mem_wait;
        mem_wait = 0;

        // Reset: everything quiet even with requests pending.
        reset_i = 1; imem_req_valid_i = 1; dmem_req_valid_i = 1; mem_req_ready_i = 1;
        mem_resp_valid_i = 1;
        @(posedge clk); #1;
        tick();
        tick();
        reset_i = 0; imem_req_valid_i = 0; dmem_req_valid_i = 0; mem_resp_valid_i = 0;
        tick();

        // Single fetch at 0x100, response two cycles later.
        imem_req_valid_i = 1; imem_req_addr_i = 32'h100; mem_req_ready_i = 1;
        settle();
        chk("single_fetch_ready", imem_req_ready_o, 1'b1);
        advance();
        imem_req_valid_i = 0;
        tick();
        mem_resp_valid_i = 1; mem_resp_data_i = 32'h0000_0013;
        settle();
        chk("single_fetch_resp", imem_resp_valid_o, 1'b1);
        chk("single_fetch_data", imem_resp_data_o, 32'h13);
        chk("single_fetch_no_d", dmem_resp_valid_o, 1'b0);
        advance();
        mem_resp_valid_i = 0;

        // Contention with a single-cycle memory.
        grants.delete();
        imem_req_valid_i = 1; imem_req_addr_i = 32'h200;
        dmem_req_valid_i = 1; dmem_req_addr_i = 32'h1000; dmem_req_we_i = 0;
        dmem_req_size_i = 2'd2; dmem_req_wdata_i = 0;
        for (int i = 0; i < 20; i++) begin
            mem_resp_valid_i = m_busy;
            mem_resp_data_i  = 32'h1000 + i;
            tick();
        end
        chk("contention_count", grants.size(), 10);
        for (int i = 0; i < 10 && i < grants.size(); i++) begin
            chk($sformatf("contention_grant%0d", i), 32'(grants[i]), (i % 5 == 4) ? 32'd1 : 32'd0);
        end
        imem_req_valid_i = 0; dmem_req_valid_i = 0;
        mem_resp_valid_i = m_busy;
        tick();
        mem_resp_valid_i = 0;
        tick();

        // Byte store to 0x2003.
        dmem_req_valid_i = 1; dmem_req_addr_i = 32'h2003; dmem_req_we_i = 1;
        dmem_req_size_i = 2'd0; dmem_req_wdata_i = 32'hA5;
        settle();
        chk("sb_we", 32'(mem_req_we_o), 32'd1);
        chk("sb_size", 32'(mem_req_size_o), 32'd0);
        chk("sb_addr", mem_req_addr_o, 32'h2003);
        chk("sb_wdata", mem_req_wdata_o, 32'hA5);
        advance();
        dmem_req_valid_i = 0; mem_resp_valid_i = 1; mem_resp_data_i = 32'h0;
        settle();
        chk("sb_ack_d", dmem_resp_valid_o, 1'b1);
        chk("sb_ack_not_i", imem_resp_valid_o, 1'b0);
        advance();
        mem_resp_valid_i = 0;

        // Flush while waiting for a fetch; response three cycles later dropped.
        imem_req_valid_i = 1; imem_req_addr_i = 32'h300;
        tick();
        imem_req_valid_i = 0; flush_i = 1;
        tick();
        flush_i = 0;
        tick();
        tick();
        mem_resp_valid_i = 1; mem_resp_data_i = 32'hDEAD_BEEF;
        settle();
        chk("flush_drop", imem_resp_valid_o, 1'b0);
        advance();
        mem_resp_valid_i = 0;
        imem_req_valid_i = 1; imem_req_addr_i = 32'h304;
        tick();
        imem_req_valid_i = 0; mem_resp_valid_i = 1; mem_resp_data_i = 32'h0000_0093;
        settle();
        chk("after_flush_fwd", imem_resp_valid_o, 1'b1);
        advance();
        mem_resp_valid_i = 0;

        // Flush in the accept cycle, then flush during a data wait.
        imem_req_valid_i = 1; imem_req_addr_i = 32'h400; flush_i = 1;
        tick();
        imem_req_valid_i = 0; flush_i = 0; mem_resp_valid_i = 1; mem_resp_data_i = 32'h1234;
        settle();
        chk("flush_accept_drop", imem_resp_valid_o, 1'b0);
        advance();
        mem_resp_valid_i = 0;
        dmem_req_valid_i = 1; dmem_req_we_i = 0; dmem_req_size_i = 2'd2; dmem_req_addr_i = 32'h3000;
        tick();
        dmem_req_valid_i = 0; flush_i = 1;
        tick();
        mem_resp_valid_i = 1; mem_resp_data_i = 32'h5555_AAAA;
        settle();
        chk("flush_waitd_fwd", dmem_resp_valid_o, 1'b1);
        chk("flush_waitd_data", dmem_resp_data_o, 32'h5555_AAAA);
        advance();
        flush_i = 0; mem_resp_valid_i = 0;

        // Reset in the middle of a data transaction, then a stray response.
        dmem_req_valid_i = 1; dmem_req_addr_i = 32'h3004;
        tick();
        dmem_req_valid_i = 0; reset_i = 1;
        tick();
        reset_i = 0; mem_resp_valid_i = 1; mem_resp_data_i = 32'hBAD0_BAD0;
        settle();
        chk("reset_stray_d", dmem_resp_valid_o, 1'b0);
        chk("reset_stray_i", imem_resp_valid_o, 1'b0);
        advance();
        mem_resp_valid_i = 0; dmem_req_valid_i = 1; dmem_req_addr_i = 32'h3008;
        settle();
        chk("reset_next_grant", dmem_req_ready_o, 1'b1);
        advance();
        dmem_req_valid_i = 0; mem_resp_valid_i = 1;
        tick();
        mem_resp_valid_i = 0;
        tick();

        // Randomized traffic against the model.
        mem_wait = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!imem_req_valid_i || last_iacc) begin
                imem_req_valid_i = ($urandom_range(0, 2) != 0);
                imem_req_addr_i  = {$urandom_range(0, 65535), 2'b00};
            end
            if (!dmem_req_valid_i || last_dacc) begin
                dmem_req_valid_i = ($urandom_range(0, 2) != 0);
                dmem_req_addr_i  = $urandom;
                dmem_req_we_i    = $urandom_range(0, 1) == 1;
                dmem_req_size_i  = 2'($urandom_range(0, 2));
                dmem_req_wdata_i = $urandom;
            end
            mem_req_ready_i  = ($urandom_range(0, 3) != 0);
            mem_resp_valid_i = m_busy ? (mem_wait == 0) : ($urandom_range(0, 19) == 0);
            mem_resp_data_i  = $urandom;
            flush_i          = ($urandom_range(0, 5) == 0);
            reset_i          = ($urandom_range(0, 249) == 0);
            tick();
            if (last_iacc || last_dacc) mem_wait = $urandom_range(0, 3);
            else if (m_busy && mem_wait > 0) mem_wait--;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port of the tiny5 core between the instruction-fetch requester (IF stage) and the data requester (MEM stage). Allows one outstanding transaction at a time and uses a three-state FSM. Data requests win ties, with a bounded-starvation guard for fetch. Routes each response back to its owner and discards fetch responses invalidated by a pipeline redirect (`flush_i`). Sits between the pipeline's imem/dmem interfaces and the external memory.

## Interface
- `DMEM_MAX_CONSEC`, default 4: maximum number of consecutive contended dmem grants before fetch is forced; legal range ≥1.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `imem_req_valid_i` in 1: fetch request valid.
- `imem_req_addr_i` in 32: fetch address; word read.
- `imem_req_ready_o` out 1: fetch request accepted this cycle.
- `imem_resp_valid_o` out 1: fetch data valid.
- `imem_resp_data_o` out 32: fetch data.
- `dmem_req_valid_i` in 1: data request valid.
- `dmem_req_addr_i` in 32: data address.
- `dmem_req_we_i` in 1: 1 = store, 0 = load.
- `dmem_req_size_i` in 2: `mem_access_size_t` (BYTE / HALF / WORD).
- `dmem_req_wdata_i` in 32: store data.
- `dmem_req_ready_o` out 1: data request accepted this cycle.
- `dmem_resp_valid_o` out 1: load data valid, or store ack.
- `dmem_resp_data_o` out 32: load data; don't-care for stores.
- `mem_req_valid_o` / `mem_req_addr_o`(32) / `mem_req_we_o` / `mem_req_size_o`(2) / `mem_req_wdata_o`(32), all out: memory request.
- `mem_req_ready_i` in 1: memory accepts the request.
- `mem_resp_valid_i` in 1: memory response valid; one response per accepted request, loads and stores alike.
- `mem_resp_data_i` in 32: response data.
- `flush_i` in 1: pipeline redirect; the in-flight or same-cycle-accepted fetch becomes stale.

## Operation
- **States:** IDLE, WAIT_I, WAIT_D.
- **IDLE, arbitration (combinational):**
  - Only one requester valid: select it.
  - Both valid: select dmem, unless `dcnt == DMEM_MAX_CONSEC`, in which case select imem.
- **IDLE, request drive:**
  - `mem_req_valid_o` = valid of the selected requester.
  - Payload is muxed from the selected requester.
  - For fetch: `we = 0`, `size = WORD`, `wdata = 0`.
- **Accept:** occurs in IDLE when `mem_req_valid_o && mem_req_ready_i`.
  - The owner's `*_req_ready_o` = 1 that cycle. The other requester's ready = 0.
  - Next state: WAIT_I or WAIT_D.
- **Request rules:** requesters hold valid and payload stable until ready. The arbiter may re-arbitrate every IDLE cycle until accept; it does not lock a choice early.
- **Starvation counter `dcnt`:**
  - Increment (saturating) on a dmem accept while `imem_req_valid_i = 1`.
  - Clear on any imem accept.
  - Clear on a dmem accept while `imem_req_valid_i = 0`.
  - Width is `$clog2(DMEM_MAX_CONSEC+1)`.
- **WAIT_x:**
  - `mem_req_valid_o = 0`, both `*_req_ready_o = 0`.
  - On `mem_resp_valid_i`: route `resp_valid` and data to the owner combinationally, then go to IDLE.
- **Fetch drop flag `stale`:**
  - Set by `flush_i` while in WAIT_I, or by `flush_i` in the same cycle as an imem accept.
  - While `stale` or `flush_i` is 1, a WAIT_I response is consumed with `imem_resp_valid_o = 0`.
  - `stale` clears when the WAIT_I response arrives.
  - `flush_i` has no effect on dmem traffic, or in IDLE with no imem accept.
- **Outside WAIT states:** `mem_resp_valid_i` in IDLE is ignored. The memory is reset by the same `reset_i`.
- **Response outputs:** `*_resp_data_o` = `mem_resp_data_i` at all times. Only the valids are gated.

## Timing
- **Reset:** while `reset_i` = 1, all valid and ready outputs are 0 and next state is IDLE with `dcnt = 0` and `stale = 0`. Data/address outputs are don't-care.
- **Mid-transaction reset:** the transaction is abandoned and no response is forwarded.
- **Request path:** combinational from `*_req_valid_i` / `mem_req_ready_i` to `mem_req_valid_o` / `*_req_ready_o`; zero added latency.
- **Response path:** combinational from `mem_resp_valid_i`.
- **Throughput:** request accepted cycle N, response at cycle M ≥ N+1 → IDLE at M+1 → next accept no earlier than M+1. A zero-wait memory gives 1 transaction per 2 cycles.
- **No accept in the response cycle:** WAIT states never assert ready.

## Test plan
- **Single fetch:** imem addr 0x100, memory ready immediately, response 0x00000013 two cycles later → `imem_req_ready_o` pulses in cycle 0; `imem_resp_valid_o` = 1 with 0x13 in cycle 2; `dmem_resp_valid_o` stays 0.
- **Contention, default parameter:** both requesters continuously valid, single-cycle memory → grant order D,D,D,D,I,D,D,D,D,I; `dcnt` reaches 4 before each I grant.
- **Store size:** dmem SB to 0x2003 with wdata 0xA5 → `mem_req_we_o` = 1, `mem_req_size_o` = BYTE, `mem_req_addr_o` = 0x2003; ack routed to `dmem_resp_valid_o` only.
- **Flush:** fetch accepted, `flush_i` pulsed in WAIT_I, response 0xDEADBEEF arrives 3 cycles later → `imem_resp_valid_o` stays 0. The next fetch's response is forwarded normally.
- **Flush at accept:** `flush_i` in the same cycle as an imem accept → that response is dropped. `flush_i` during WAIT_D → dmem response forwarded unchanged.
- **Reset mid-transaction:** `reset_i` asserted in WAIT_D, then a stray `mem_resp_valid_i` the cycle after reset deasserts → no `*_resp_valid_o`, state IDLE, and the next request is granted normally.
